fast_nms_kp_scheduler: RTL and testbench

Sequences the keypoint stream from the 7×7 FAST non-maximum-suppression stage into a per-frame list of keypoint coordinate records. It tracks pixel coordinates from the NMS output syncs and masks the window border. Surviving keypoints are buffered in a small FIFO and drained to the descriptor stage over a valid/ready handshake. Each frame is closed with an end-of-frame record carrying the keypoint count.

---
 rtl/fast_pkg.sv | 23 ++
 rtl/fast_kp_fifo.sv | 63 ++++++
 rtl/fast_nms_kp_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fast_nms_kp_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// fast_pkg: shared types and constants for the FAST keypoint scheduler.
// Holds the FSM state enum, the keypoint record and window constants.
package fast_pkg;

  localparam int FAST_WIN    = 7;
  localparam int FAST_BORDER = FAST_WIN / 2;
  localparam int KP_COORD_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    LAST
  } kp_state_e;

  // 'type' is a reserved word, so the field is kp_type
  typedef struct packed {
    logic [KP_COORD_W-1:0] x;
    logic [KP_COORD_W-1:0] y;
    logic [1:0]            kp_type;
  } kp_rec_t;

endpackage

// File: rtl/fast_kp_fifo.sv
// fast_kp_fifo: synchronous FIFO of kp_rec_t with a registered head.
// Ports: push/wr_data in, pop/rd_data/rd_valid out, full/empty status.
module fast_kp_fifo
  import fast_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  kp_rec_t wr_data,
  input  logic    pop,
  output kp_rec_t rd_data,
  output logic    rd_valid,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  kp_rec_t        mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  kp_rec_t        rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // The head register only sees entries written on an earlier
  // edge (old wr_ptr), so a fresh entry shows one cycle later.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    rd_valid_d = (rd_ptr_d != wr_ptr_q);
    rd_data_d  = rd_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: rtl/fast_nms_kp_scheduler.sv
// fast_nms_kp_scheduler: turns the FAST NMS mark stream into per-frame
// keypoint records closed by an end-of-frame count record.
// Ports: i_image_* stream in; o_kp_*/i_kp_ready record handshake out;
// o_overflow, o_frame_skip, o_busy status. Define
// FAST_NMS_BORDER_MASK_EN to mask the BORDER-pixel image margin.
module fast_nms_kp_scheduler
  import fast_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int BORDER     = FAST_BORDER,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_KP     = 1024,
  parameter int COORD_W    = KP_COORD_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_image_vs,
  input  logic               i_image_hs,
  input  logic               i_image_en,
  input  logic [7:0]         i_image_data,
  output logic               o_kp_valid,
  input  logic               i_kp_ready,
  output logic [COORD_W-1:0] o_kp_x,
  output logic [COORD_W-1:0] o_kp_y,
  output logic [1:0]         o_kp_type,
  output logic               o_kp_last,
  output logic [COORD_W:0]   o_kp_count,
  output logic               o_overflow,
  output logic               o_frame_skip,
  output logic               o_busy
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] KP_LIMIT = CW1'(MAX_KP);

  kp_state_e          state_q, state_d;
  logic               vs_q, hs_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               skip_q, skip_d;
  logic               vs_rise, vs_fall, hs_fall, start;
  logic               in_win, kp_hit, budget_ok, push, pop;
  logic               fifo_full, fifo_empty, fifo_valid;
  kp_rec_t            wr_rec, rd_rec;

  assign vs_rise = i_image_vs & ~vs_q;
  assign vs_fall = ~i_image_vs & vs_q;
  assign hs_fall = ~i_image_hs & hs_q;
  assign start   = (state_q == IDLE) & vs_rise;

`ifdef FAST_NMS_BORDER_MASK_EN
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(IMG_W - 1 - BORDER);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(IMG_H - 1 - BORDER);
  logic unused_bits;
  assign unused_bits = ^i_image_data[7:2];
  assign in_win = (x_q >= X_LO) && (x_q <= X_HI) &&
                  (y_q >= Y_LO) && (y_q <= Y_HI);
`else
  logic unused_bits;
  assign unused_bits = ^{i_image_data[7:2], 32'(BORDER + IMG_W + IMG_H)};
  assign in_win = 1'b1;
`endif

  assign kp_hit = (state_q == ACTIVE) & i_image_en &
                  (i_image_data[1:0] != 2'b00) & in_win;
  assign budget_ok = (cnt_q < KP_LIMIT);
  assign pop  = fifo_valid & i_kp_ready;
  assign push = kp_hit & budget_ok & (~fifo_full | pop);

  always_comb begin
    wr_rec         = '0;
    wr_rec.x       = KP_COORD_W'(x_q);
    wr_rec.y       = KP_COORD_W'(y_q);
    wr_rec.kp_type = i_image_data[1:0];
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    skip_d = vs_rise & ((state_q == FLUSH) | (state_q == LAST));
    if (start) begin
      x_d   = '0;
      y_d   = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (hs_fall) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else if (i_image_en) begin
        x_d = x_q + 1'b1;
      end
      if (push) begin
        cnt_d = cnt_q + 1'b1;
      end
      // budget drops are silent; only a full FIFO flags overflow
      if (kp_hit & budget_ok & fifo_full & ~pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // vs_q resets high so a vs already high after reset is not
  // mistaken for a frame start: partial frames are never reported.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_q   <= 1'b1;
      hs_q   <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      vs_q   <= i_image_vs;
      hs_q   <= i_image_hs;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      skip_q <= skip_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (vs_rise)    state_d = ACTIVE;
      ACTIVE: if (vs_fall)    state_d = FLUSH;
      FLUSH:  if (fifo_empty) state_d = LAST;
      LAST:   if (i_kp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != IDLE);
    o_kp_last  = (state_q == LAST);
    o_kp_valid = fifo_valid | o_kp_last;
  end

  // FIFO head is zero whenever it is not valid, so the end
  // record naturally carries zero coordinates and type.
  assign o_kp_x       = COORD_W'(rd_rec.x);
  assign o_kp_y       = COORD_W'(rd_rec.y);
  assign o_kp_type    = rd_rec.kp_type;
  assign o_kp_count   = cnt_q;
  assign o_overflow   = ovf_q;
  assign o_frame_skip = skip_q;

  fast_kp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (push),
    .wr_data  (wr_rec),
    .pop      (pop),
    .rd_data  (rd_rec),
    .rd_valid (fifo_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_fast_nms_kp_scheduler.sv
// tb_fast_nms_kp_scheduler: scoreboard bench for the keypoint scheduler.
// Two instances share the stream: A with a large budget, B with MAX_KP=4.
module tb_fast_nms_kp_scheduler;
  import fast_pkg::*;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int B  = 3;
  localparam int CW = 12;

  typedef struct {
    int x;
    int y;
    int t;
    bit last;
    int cnt;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, vs, hs, en, ready, rnd;
  logic [7:0] data;

  logic          va, la, oa, sa, ba;
  logic [CW-1:0] xa, ya;
  logic [1:0]    ta;
  logic [CW:0]   ca;
  logic          vb, lb, ob, sb, bb;
  logic [CW-1:0] xb, yb;
  logic [1:0]    tb;
  logic [CW:0]   cb;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   m_cnt[2];
  bit   m_ovf[2];
  int   n_chk = 0;
  int   n_fail = 0;
  int   skip_a = 0;
  int   skip_b = 0;
  bit   hold_a = 0;
  bit   hold_b = 0;
  logic [27:0] hv_a, hv_b;

  always #5 clk = ~clk;

  fast_nms_kp_scheduler #(
    .IMG_W(W), .IMG_H(H), .BORDER(B), .FIFO_DEPTH(16),
    .MAX_KP(1024), .COORD_W(CW)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_image_vs(vs),
    .i_image_hs(hs), .i_image_en(en), .i_image_data(data),
    .o_kp_valid(va), .i_kp_ready(ready), .o_kp_x(xa),
    .o_kp_y(ya), .o_kp_type(ta), .o_kp_last(la),
    .o_kp_count(ca), .o_overflow(oa), .o_frame_skip(sa),
    .o_busy(ba)
  );

  fast_nms_kp_scheduler #(
    .IMG_W(W), .IMG_H(H), .BORDER(B), .FIFO_DEPTH(16),
    .MAX_KP(4), .COORD_W(CW)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_image_vs(vs),
    .i_image_hs(hs), .i_image_en(en), .i_image_data(data),
    .o_kp_valid(vb), .i_kp_ready(ready), .o_kp_x(xb),
    .o_kp_y(yb), .o_kp_type(tb), .o_kp_last(lb),
    .o_kp_count(cb), .o_overflow(ob), .o_frame_skip(sb),
    .o_busy(bb)
  );

  task automatic chk_eq(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_rec(string p, exp_t e, int x, int y, int t,
                         bit last, int cnt, bit ovf);
    chk_eq({p, "_last"}, last, e.last);
    chk_eq({p, "_x"}, x, e.x);
    chk_eq({p, "_y"}, y, e.y);
    chk_eq({p, "_type"}, t, e.t);
    if (e.last) begin
      chk_eq({p, "_count"}, cnt, e.cnt);
      chk_eq({p, "_overflow"}, ovf, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && hold_a) chk_eq("A_hold", {va, la, xa, ya, ta}, hv_a);
    hold_a = rst_n && va && !ready;
    hv_a   = {va, la, xa, ya, ta};
    if (rst_n && va && ready) begin
      chk_eq("A_expected", q_a.size() > 0, 1);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        cmp_rec("A", ea, xa, ya, ta, la, ca, oa);
      end
    end
    if (sa) skip_a++;
  end

  always @(negedge clk) begin
    if (rst_n && hold_b) chk_eq("B_hold", {vb, lb, xb, yb, tb}, hv_b);
    hold_b = rst_n && vb && !ready;
    hv_b   = {vb, lb, xb, yb, tb};
    if (rst_n && vb && ready) begin
      chk_eq("B_expected", q_b.size() > 0, 1);
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        cmp_rec("B", eb, xb, yb, tb, lb, cb, ob);
      end
    end
    if (sb) skip_b++;
  end

  function automatic logic [7:0] pat(int p, int x, int y);
    logic [7:0] d;
    d = 8'h00;
    case (p)
      1: if (x == 5 && y == 4) d = 8'h01;
      2: if (y == 4) begin
           case (x)
             2:  d = 8'h06;
             6:  d = 8'hFC;
             12: d = 8'hFB;
             13: d = 8'h01;
             default: d = 8'h00;
           endcase
         end
      3: if (y == 3 || y == 4) d = 8'(x % 3 + 1);
      4: if (y == 5 && x >= 3 && x <= 8) d = 8'h02;
      5: if (y == 3 && (x == 4 || x == 6 || x == 8)) d = 8'h01;
      6: if (y == 4 && x >= 3 && x <= 12) d = 8'h03;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  function automatic bit eligible(int x, int y);
`ifdef FAST_NMS_BORDER_MASK_EN
    return x >= B && x <= W - 1 - B && y >= B && y <= H - 1 - B;
`else
    return (x >= 0) && (y >= 0);
`endif
  endfunction

  task automatic push_exp(int k, exp_t e);
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // stall: ready held low all frame, so FIFO occupancy == accepted count
  task automatic model_pix(int px, int py, logic [7:0] d, bit stall);
    exp_t e;
    int   lim;
    if (d[1:0] == 2'b00 || !eligible(px, py)) return;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 1024 : 4;
      if (m_cnt[k] >= lim) continue;
      if (stall && m_cnt[k] >= 16) begin
        m_ovf[k] = 1'b1;
        continue;
      end
      e = '{x: px, y: py, t: int'(d[1:0]), last: 1'b0, cnt: 0, ovf: 1'b0};
      push_exp(k, e);
      m_cnt[k]++;
    end
  endtask

  task automatic push_end();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e = '{x: 0, y: 0, t: 0, last: 1'b1, cnt: m_cnt[k], ovf: m_ovf[k]};
      push_exp(k, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || ba || bb) && n < 600) begin
      tick();
      n++;
    end
    chk_eq("drain", q_a.size() + q_b.size() + int'(ba) + int'(bb), 0);
    rnd   = 1'b0;
    ready = 1'b1;
  endtask

  task automatic drive_line(int p, int y, bit exp_on, bit stall);
    hs = 1'b1;
    tick();
    for (int x = 0; x < W; x++) begin
      en   = 1'b1;
      data = pat(p, x, y);
      if (exp_on) model_pix(x, y, data, stall);
      tick();
    end
    en   = 1'b0;
    data = 8'h00;
    tick();
    hs = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_frame(int p, bit stall, bit exp_on, bit r);
    m_cnt = '{0, 0};
    m_ovf = '{1'b0, 1'b0};
    rnd   = r;
    ready = !stall;
    vs    = 1'b1;
    tick();
    tick();
    for (int y = 0; y < H; y++) drive_line(p, y, exp_on, stall);
    vs = 1'b0;
    tick();
    if (exp_on) push_end();
    if (stall) ready = 1'b1;
    wait_done();
    if (exp_on) begin
      chk_eq("A_count_held", ca, m_cnt[0]);
      chk_eq("B_count_held", cb, m_cnt[1]);
    end
  endtask

  initial begin
    int n;
    vs = 0; hs = 0; en = 0; data = 0;
    ready = 0; rnd = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid", va, 0);
    chk_eq("rst_last", la, 0);
    chk_eq("rst_xyt", {xa, ya, ta}, 0);
    chk_eq("rst_count", ca, 0);
    chk_eq("rst_overflow", oa, 0);
    chk_eq("rst_skip", sa, 0);
    chk_eq("rst_busy", ba, 0);
    chk_eq("rst_b_valid", vb, 0);
    rst_n = 1;
    ready = 1;
    tick();
    tick();

    run_frame(1, 1'b0, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1, 1'b0);
    run_frame(3, 1'b1, 1'b1, 1'b0);
    run_frame(4, 1'b0, 1'b1, 1'b1);

    // empty frame parked in LAST, then a frame start that must be skipped
    m_cnt = '{0, 0};
    m_ovf = '{1'b0, 1'b0};
    skip_a = 0;
    skip_b = 0;
    vs = 1;
    repeat (3) tick();
    ready = 0;
    vs = 0;
    tick();
    push_end();
    n = 0;
    while (!(la && lb) && n < 20) begin
      tick();
      n++;
    end
    chk_eq("park_last", {la, lb}, 2'b11);
    run_frame(1, 1'b1, 1'b0, 1'b0);
    chk_eq("A_skip_pulses", skip_a, 1);
    chk_eq("B_skip_pulses", skip_b, 1);

    // reset mid-line with records queued
    ready = 0;
    m_cnt = '{0, 0};
    m_ovf = '{1'b0, 1'b0};
    vs = 1;
    tick();
    tick();
    for (int y = 0; y < 4; y++) drive_line(5, y, 1'b1, 1'b1);
    hs = 1;
    tick();
    for (int x = 0; x < 6; x++) begin
      en = 1;
      data = pat(6, x, 4);
      tick();
    end
    chk_eq("pre_rst_valid", va, 1);
    rst_n = 0;
    #2;
    chk_eq("mid_rst_valid", va, 0);
    chk_eq("mid_rst_last", la, 0);
    chk_eq("mid_rst_xyt", {xa, ya, ta}, 0);
    chk_eq("mid_rst_count", ca, 0);
    chk_eq("mid_rst_overflow", oa, 0);
    chk_eq("mid_rst_busy", ba, 0);
    q_a.delete();
    q_b.delete();
    tick();
    rst_n = 1;
    for (int x = 6; x < W; x++) begin
      en = 1;
      data = pat(6, x, 4);
      tick();
    end
    en = 0;
    data = 0;
    tick();
    hs = 0;
    tick();
    for (int y = 5; y < H; y++) drive_line(6, 4, 1'b0, 1'b0);
    vs = 0;
    ready = 1;
    tick();
    repeat (10) tick();
    wait_done();
    chk_eq("post_rst_busy", ba, 0);

    run_frame(6, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
